// File: rtl/prbs_pkg.sv
// Shared LFSR definitions for the PRBS generator/checker pair.
// Both ends import this so their taps can never drift apart.
package prbs_pkg;

  localparam int WIDTH = 24;

  // Feedback taps x^24+x^23+x^22+x^17+1 -> state bits 23, 22, 21, 16
  localparam logic [WIDTH-1:0] TAP_MASK = 24'hE1_0000;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAP_MASK)};
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Stream/status bundle between the channel side and the PRBS checker.
interface prbs_checker_if
  import prbs_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             enable;
  logic [WIDTH-1:0] data_in;
  logic             clear_cnt;
  logic             locked;
  logic             word_err;
  logic [CNT_W-1:0] err_words;
  logic [CNT_W-1:0] err_bits;

  modport master (
    output enable, data_in, clear_cnt,
    input  locked, word_err, err_words, err_bits
  );

  modport slave (
    input  enable, data_in, clear_cnt,
    output locked, word_err, err_words, err_bits
  );

endinterface

// File: rtl/prbs_checker_popcount.sv
// Combinational population count of a mismatch vector.
module popcount24
  import prbs_pkg::*;
(
  input  logic [WIDTH-1:0] i_vec,
  output logic [4:0]       o_cnt
);

  // Sum of set bits in the difference word
  always_comb begin
    o_cnt = 5'd0;
    for (int i = 0; i < WIDTH; i++) begin
      o_cnt = o_cnt + {4'd0, i_vec[i]};
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: reseeds from the stream while searching,
// then flywheels its own reference LFSR and counts word/bit errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input logic          clk,
  input logic          reset,
  prbs_checker_if.slave bus
);

  localparam logic [7:0]       LOCK_THR   = 8'(LOCK_COUNT);
  localparam logic [7:0]       UNLOCK_THR = 8'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  prbs_state_e      r_state, w_state_next;
  logic [WIDTH-1:0] r_ref, w_ref_next, w_exp, w_diff;
  logic             r_have_ref, w_have_ref_next;
  logic [7:0]       r_match_cnt, w_match_next;
  logic [7:0]       r_miss_cnt, w_miss_next;
  logic             w_mismatch;
  logic [4:0]       w_pop;
  logic [CNT_W:0]   w_bits_sum;
  logic [CNT_W-1:0] r_err_words, w_err_words_next;
  logic [CNT_W-1:0] r_err_bits, w_err_bits_next;
  logic             r_word_err;
  logic             r_locked;

  assign w_exp  = lfsr_next(r_ref);
  assign w_diff = bus.data_in ^ w_exp;

  popcount24 u_popcount (
    .i_vec (w_diff),
    .o_cnt (w_pop)
  );

  // Extra top bit catches the carry so the bit counter clamps instead of wrapping
  assign w_bits_sum = {1'b0, r_err_bits} + {{(CNT_W-4){1'b0}}, w_pop};

  // Lock FSM next state plus reference/match/miss bookkeeping
  always_comb begin
    w_state_next    = r_state;
    w_ref_next      = r_ref;
    w_have_ref_next = r_have_ref;
    w_match_next    = r_match_cnt;
    w_miss_next     = r_miss_cnt;
    w_mismatch      = 1'b0;
    if (bus.enable) begin
      case (r_state)
        SEARCH: begin
          w_ref_next      = bus.data_in;
          w_have_ref_next = |bus.data_in;
          if (r_have_ref && (bus.data_in == w_exp) && (|bus.data_in)) begin
            if ((r_match_cnt + 8'd1) == LOCK_THR) begin
              w_state_next = LOCKED;
              w_match_next = 8'd0;
              w_miss_next  = 8'd0;
            end else begin
              w_match_next = r_match_cnt + 8'd1;
            end
          end else begin
            w_match_next = 8'd0;
          end
        end
        LOCKED: begin
          w_ref_next = w_exp;
          if (|w_diff) begin
            w_mismatch = 1'b1;
            if ((r_miss_cnt + 8'd1) == UNLOCK_THR) begin
              w_state_next    = SEARCH;
              w_miss_next     = 8'd0;
              w_match_next    = 8'd0;
              w_ref_next      = bus.data_in;
              w_have_ref_next = |bus.data_in;
            end else begin
              w_miss_next = r_miss_cnt + 8'd1;
            end
          end else begin
            w_miss_next = 8'd0;
          end
        end
        default: begin
          w_state_next    = SEARCH;
          w_match_next    = 8'd0;
          w_miss_next     = 8'd0;
          w_have_ref_next = 1'b0;
        end
      endcase
    end else begin
      w_mismatch = 1'b0;
    end
  end

  // Saturating error counters; a clear in the same cycle as an error wins
  always_comb begin
    w_err_words_next = r_err_words;
    w_err_bits_next  = r_err_bits;
    if (bus.clear_cnt) begin
      w_err_words_next = {CNT_W{1'b0}};
      w_err_bits_next  = {CNT_W{1'b0}};
    end else if (w_mismatch) begin
      w_err_words_next = (r_err_words == CNT_MAX) ? CNT_MAX : (r_err_words + CNT_ONE);
      w_err_bits_next  = w_bits_sum[CNT_W] ? CNT_MAX : w_bits_sum[CNT_W-1:0];
    end else begin
      w_err_words_next = r_err_words;
      w_err_bits_next  = r_err_bits;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ref       <= {WIDTH{1'b0}};
      r_have_ref  <= 1'b0;
      r_match_cnt <= 8'd0;
      r_miss_cnt  <= 8'd0;
      r_err_words <= {CNT_W{1'b0}};
      r_err_bits  <= {CNT_W{1'b0}};
      r_word_err  <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_ref       <= w_ref_next;
      r_have_ref  <= w_have_ref_next;
      r_match_cnt <= w_match_next;
      r_miss_cnt  <= w_miss_next;
      r_err_words <= w_err_words_next;
      r_err_bits  <= w_err_bits_next;
      r_word_err  <= w_mismatch;
      r_locked    <= (w_state_next == LOCKED);
    end
  end

  assign bus.locked    = r_locked;
  assign bus.word_err  = r_word_err;
  assign bus.err_words = r_err_words;
  assign bus.err_bits  = r_err_bits;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a behavioural model queues expected outputs
// per driven cycle; scenario tasks add targeted checks. A narrow-counter instance covers saturation.
module tb_prbs_checker;
  import prbs_pkg::*;

  localparam int LOCK_N   = 8;
  localparam int UNLOCK_N = 4;
  localparam int SAT_W    = 8;

  typedef struct packed {
    logic        locked;
    logic        word_err;
    logic [15:0] words;
    logic [15:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prbs_checker_if #(.CNT_W(16))    bus ();
  prbs_checker_if #(.CNT_W(SAT_W)) sbus ();

  prbs_checker #(.LOCK_COUNT(LOCK_N), .UNLOCK_ERRS(UNLOCK_N), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  prbs_checker #(.LOCK_COUNT(LOCK_N), .UNLOCK_ERRS(UNLOCK_N), .CNT_W(SAT_W)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  prbs_state_e m_state;
  logic [23:0] m_ref;
  logic        m_have;
  int          m_match, m_miss, m_words, m_bits;
  logic [23:0] g, g2;

  // Scoreboard monitor: compare every queued expectation one step after the edge
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (bus.locked !== mon_e.locked) begin
        errors++; $display("FAIL sb_locked t=%0t got %b exp %b", $time, bus.locked, mon_e.locked);
      end
      checks++;
      if (bus.word_err !== mon_e.word_err) begin
        errors++; $display("FAIL sb_word_err t=%0t got %b exp %b", $time, bus.word_err, mon_e.word_err);
      end
      checks++;
      if (bus.err_words !== mon_e.words) begin
        errors++; $display("FAIL sb_err_words t=%0t got %0d exp %0d", $time, bus.err_words, mon_e.words);
      end
      checks++;
      if (bus.err_bits !== mon_e.bits) begin
        errors++; $display("FAIL sb_err_bits t=%0t got %0d exp %0d", $time, bus.err_bits, mon_e.bits);
      end
    end
  end

  // Drive one cycle on the main DUT, advance the reference model and queue its expectation
  task automatic step(input logic en, input logic [23:0] d, input logic clr, input logic rst);
    logic [23:0] e, diff;
    logic        we;
    exp_t        x;
    @(negedge clk);
    bus.enable = en; bus.data_in = d; bus.clear_cnt = clr; reset = rst;
    we = 1'b0;
    if (rst) begin
      m_state = SEARCH; m_ref = 24'h0; m_have = 1'b0;
      m_match = 0; m_miss = 0; m_words = 0; m_bits = 0;
    end else begin
      if (en) begin
        if (m_state == SEARCH) begin
          if (m_have && d == lfsr_next(m_ref) && d != 24'h0) m_match++;
          else m_match = 0;
          m_ref = d; m_have = (d != 24'h0);
          if (m_match == LOCK_N) begin
            m_state = LOCKED; m_miss = 0; m_match = 0;
          end
        end else begin
          e = lfsr_next(m_ref); m_ref = e; diff = d ^ e;
          if (diff != 24'h0) begin
            we = 1'b1;
            m_words = (m_words + 1 > 65535) ? 65535 : m_words + 1;
            m_bits  = (m_bits + $countones(diff) > 65535) ? 65535 : m_bits + $countones(diff);
            m_miss++;
            if (m_miss == UNLOCK_N) begin
              m_state = SEARCH; m_match = 0; m_miss = 0; m_ref = d; m_have = (d != 24'h0);
            end
          end else begin
            m_miss = 0;
          end
        end
      end
      if (clr) begin m_words = 0; m_bits = 0; end
    end
    x.locked = (m_state == LOCKED); x.word_err = we;
    x.words = m_words[15:0]; x.bits = m_bits[15:0];
    sb_q.push_back(x);
    @(posedge clk); #2;
  endtask

  task automatic sstep(input logic en, input logic [23:0] d, input logic clr);
    @(negedge clk);
    sbus.enable = en; sbus.data_in = d; sbus.clear_cnt = clr;
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    step(1'b1, 24'hABCDEF, 1'b1, 1'b1);
    step(1'b1, 24'h123456, 1'b0, 1'b1);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", bus.locked); end
    checks++; if (bus.err_words !== 16'h0) begin errors++; $display("FAIL reset_words got %0d exp 0", bus.err_words); end
    checks++; if (bus.err_bits !== 16'h0) begin errors++; $display("FAIL reset_bits got %0d exp 0", bus.err_bits); end
    checks++; if (sbus.locked !== 1'b0 || sbus.err_words !== 8'h0) begin
      errors++; $display("FAIL reset_sat got locked=%b words=%0d exp 0/0", sbus.locked, sbus.err_words);
    end
  endtask

  task automatic test_lock();
    step(1'b0, 24'h0, 1'b0, 1'b0);
    g = 24'h000001;
    for (int i = 1; i <= 10; i++) begin
      g = lfsr_next(g);
      step(1'b1, g, 1'b0, 1'b0);
      if (i == 8) begin
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_early got %b exp 0", bus.locked); end
      end
      if (i == 9) begin
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_after_8_matches got %b exp 1", bus.locked); end
      end
    end
    checks++; if (bus.err_words !== 16'h0 || bus.err_bits !== 16'h0) begin
      errors++; $display("FAIL lock_counts got %0d/%0d exp 0/0", bus.err_words, bus.err_bits);
    end
  endtask

  task automatic test_single_error();
    g = lfsr_next(g);
    step(1'b1, g ^ 24'h000021, 1'b0, 1'b0);
    checks++; if (bus.word_err !== 1'b1) begin errors++; $display("FAIL single_word_err got %b exp 1", bus.word_err); end
    checks++; if (bus.err_words !== 16'd1) begin errors++; $display("FAIL single_words got %0d exp 1", bus.err_words); end
    checks++; if (bus.err_bits !== 16'd2) begin errors++; $display("FAIL single_bits got %0d exp 2", bus.err_bits); end
    g = lfsr_next(g);
    step(1'b1, g, 1'b0, 1'b0);
    checks++; if (bus.word_err !== 1'b0 || bus.locked !== 1'b1) begin
      errors++; $display("FAIL single_next_clean got err=%b locked=%b exp 0/1", bus.word_err, bus.locked);
    end
  endtask

  task automatic test_unlock_relock();
    step(1'b0, 24'h0, 1'b1, 1'b0);
    checks++; if (bus.locked !== 1'b1 || bus.err_words !== 16'h0) begin
      errors++; $display("FAIL clear_keeps_lock got locked=%b words=%0d exp 1/0", bus.locked, bus.err_words);
    end
    for (int i = 1; i <= 4; i++) begin
      g = lfsr_next(g);
      step(1'b1, g ^ 24'h000008, 1'b0, 1'b0);
      if (i == 3) begin
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL unlock_early got %b exp 1", bus.locked); end
      end
    end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL unlock_after_4 got %b exp 0", bus.locked); end
    checks++; if (bus.err_words !== 16'd4) begin errors++; $display("FAIL unlock_words got %0d exp 4", bus.err_words); end
    for (int i = 1; i <= 9; i++) begin
      g = lfsr_next(g);
      step(1'b1, g, 1'b0, 1'b0);
      if (i == 8) begin
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL relock_early got %b exp 0", bus.locked); end
      end
    end
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL relock got %b exp 1", bus.locked); end
    checks++; if (bus.err_words !== 16'd4) begin errors++; $display("FAIL relock_words got %0d exp 4", bus.err_words); end
  endtask

  task automatic test_gaps_and_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 24'($urandom), 1'b0, 1'b0);
    g = lfsr_next(g);
    step(1'b1, g, 1'b0, 1'b0);
    checks++; if (bus.word_err !== 1'b0 || bus.locked !== 1'b1) begin
      errors++; $display("FAIL gap_frozen_ref got err=%b locked=%b exp 0/1", bus.word_err, bus.locked);
    end
    g = lfsr_next(g);
    step(1'b1, g ^ 24'h800001, 1'b0, 1'b0);
    g = lfsr_next(g);
    step(1'b1, g ^ 24'h000100, 1'b1, 1'b1);
    checks++; if (bus.locked !== 1'b0 || bus.word_err !== 1'b0) begin
      errors++; $display("FAIL midreset_status got locked=%b err=%b exp 0/0", bus.locked, bus.word_err);
    end
    checks++; if (bus.err_words !== 16'h0 || bus.err_bits !== 16'h0) begin
      errors++; $display("FAIL midreset_counts got %0d/%0d exp 0/0", bus.err_words, bus.err_bits);
    end
    step(1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_stream();
    for (int i = 0; i < 12; i++) step(1'b1, 24'h000000, 1'b0, 1'b0);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL zero_locked got %b exp 0", bus.locked); end
    checks++; if (bus.err_words !== 16'h0 || bus.err_bits !== 16'h0) begin
      errors++; $display("FAIL zero_counts got %0d/%0d exp 0/0", bus.err_words, bus.err_bits);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk); bus.enable = 1'b0;
    g2 = 24'h000001;
    for (int i = 0; i < 10; i++) begin g2 = lfsr_next(g2); sstep(1'b1, g2, 1'b0); end
    checks++; if (sbus.locked !== 1'b1) begin errors++; $display("FAIL sat_lock got %b exp 1", sbus.locked); end
    // 253 single-bit errors, never four in a row
    for (int k = 0; k < 85; k++) begin
      for (int j = 0; j < ((k == 84) ? 1 : 3); j++) begin
        g2 = lfsr_next(g2); sstep(1'b1, g2 ^ 24'h000001, 1'b0);
      end
      g2 = lfsr_next(g2); sstep(1'b1, g2, 1'b0);
    end
    checks++; if (sbus.err_words !== 8'd253 || sbus.err_bits !== 8'd253) begin
      errors++; $display("FAIL sat_preload got %0d/%0d exp 253/253", sbus.err_words, sbus.err_bits);
    end
    g2 = lfsr_next(g2); sstep(1'b1, g2 ^ 24'h00001F, 1'b0);
    checks++; if (sbus.err_words !== 8'd254 || sbus.err_bits !== 8'd255) begin
      errors++; $display("FAIL sat_bit_clamp got %0d/%0d exp 254/255", sbus.err_words, sbus.err_bits);
    end
    g2 = lfsr_next(g2); sstep(1'b1, g2 ^ 24'h000002, 1'b0);
    g2 = lfsr_next(g2); sstep(1'b1, g2 ^ 24'h000002, 1'b0);
    checks++; if (sbus.err_words !== 8'd255 || sbus.err_bits !== 8'd255 || sbus.locked !== 1'b1) begin
      errors++; $display("FAIL sat_hold got %0d/%0d locked=%b exp 255/255/1", sbus.err_words, sbus.err_bits, sbus.locked);
    end
    g2 = lfsr_next(g2); sstep(1'b1, g2, 1'b0);
    g2 = lfsr_next(g2); sstep(1'b1, g2 ^ 24'h000040, 1'b1);
    checks++; if (sbus.word_err !== 1'b1 || sbus.err_words !== 8'd0 || sbus.err_bits !== 8'd0 || sbus.locked !== 1'b1) begin
      errors++; $display("FAIL sat_clear_wins got err=%b %0d/%0d locked=%b exp 1 0/0 1",
                         sbus.word_err, sbus.err_words, sbus.err_bits, sbus.locked);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0;  bus.data_in = 24'h0;  bus.clear_cnt = 1'b0;
    sbus.enable = 1'b0; sbus.data_in = 24'h0; sbus.clear_cnt = 1'b0;
    test_reset();
    test_lock();
    test_single_error();
    test_unlock_relock();
    test_gaps_and_reset();
    test_zero_stream();
    test_saturation();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain got %0d left exp 0", sb_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
